// File: rtl/division_pkg.sv
// Shared math package for the iterative arithmetic units.
// Holds the common control-state enum and small elaboration-time helpers
// used to size counters.
package division_pkg;

  // Control states shared by the iterative math units.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Bits needed to hold the values 0..n-1 (never less than one bit).
  function automatic int unsigned cnt_bits(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration (purely combinational).
// The partial remainder is shifted left with the next dividend bit appended
// and the divisor is trial-subtracted; the subtraction is kept only when it
// does not go negative.
//
// Ports:
//   rem          - current partial remainder (always < divisor)
//   dividend_bit - next dividend bit, MSB first
//   divisor      - divisor
//   rem_next     - updated partial remainder
//   q_bit        - quotient bit produced by this iteration
`ifndef WIDTH
  `define WIDTH 32
`endif

module div_step
  import division_pkg::*;
#(
  parameter int unsigned WIDTH = `WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  always_comb begin
    trial = {rem, dividend_bit};
    diff  = trial - {1'b0, divisor};
    // Because rem < divisor, trial < 2*divisor, so a successful subtraction
    // always fits back into WIDTH bits.
    if (trial >= {1'b0, divisor}) begin
      q_bit    = 1'b1;
      rem_next = diff[WIDTH-1:0];
    end else begin
      q_bit    = 1'b0;
      rem_next = trial[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/division.sv
// Unsigned fixed-point divider, radix-2 restoring, one quotient bit per clock.
// Computes floor((a << Q_BITS) / b) over N = WIDTH+Q_BITS iterations, with
// saturation on overflow and a dedicated divide-by-zero flag.
//
// Ports:
//   clk         - clock, rising edge
//   rst_n       - asynchronous active-low reset
//   start       - request a division (honoured only in IDLE)
//   a           - dividend, unsigned Q format, sampled with start
//   b           - divisor, unsigned Q format, sampled with start
//   busy        - operation in RUN or DONE
//   valid       - one-cycle pulse: result/flags are new
//   result      - quotient, Q format (all ones on saturation or b == 0)
//   div_by_zero - last operation had b == 0
//   overflow    - last quotient did not fit WIDTH bits
`ifndef WIDTH
  `define WIDTH 32
`endif
`ifndef Q_BITS
  `define Q_BITS 16
`endif

module division
  import division_pkg::*;
#(
  parameter int unsigned WIDTH  = `WIDTH,
  parameter int unsigned Q_BITS = `Q_BITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int unsigned N  = WIDTH + Q_BITS;
  localparam int unsigned CW = cnt_bits(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  div_state_t state;
  div_state_t state_next;

  logic [CW-1:0]    cnt;
  logic             iter_done;
  // Holds the extended dividend; quotient bits shift in from the LSB as
  // dividend bits leave from the MSB, so after N steps it holds the quotient.
  logic [N-1:0]     shreg;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] rem;

  logic [WIDTH-1:0] rem_step;
  logic             q_step;

  logic accept;
  logic zero_div;
  logic finish;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem         (rem),
    .dividend_bit(shreg[N-1]),
    .divisor     (divisor),
    .rem_next    (rem_step),
    .q_bit       (q_step)
  );

  // Control decode and next-state logic.
  always_comb begin
    accept     = (state == IDLE) && start;
    zero_div   = (b == '0);
    finish     = (state == RUN) && iter_done;
    state_next = state;
    busy       = (state != IDLE);
    valid      = (state == DONE);
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_next = zero_div ? DONE : RUN;
        end
      end
      RUN: begin
        if (iter_done) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Iteration datapath. The counter stops at N-1; iter_done marks that the
  // last iteration has been applied, and the following RUN edge enters DONE
  // while the result registers capture the finished quotient.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      iter_done <= 1'b0;
      shreg     <= '0;
      divisor   <= '0;
      rem       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept && !zero_div) begin
            shreg     <= N'(a) << Q_BITS;
            divisor   <= b;
            rem       <= '0;
            cnt       <= '0;
            iter_done <= 1'b0;
          end
        end
        RUN: begin
          if (!iter_done) begin
            shreg <= {shreg[N-2:0], q_step};
            rem   <= rem_step;
            if (cnt == LAST) begin
              iter_done <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Result and flags change only when an operation enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result      <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else if (accept && zero_div) begin
      result      <= '1;
      div_by_zero <= 1'b1;
      overflow    <= 1'b0;
    end else if (finish) begin
      div_by_zero <= 1'b0;
      if ((shreg >> WIDTH) != '0) begin
        result   <= '1;
        overflow <= 1'b1;
      end else begin
        result   <= shreg[WIDTH-1:0];
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_division.sv
// Self-checking bench for the fixed-point divider: directed vectors, random
// operands against an arithmetic reference, restart/ignore rules and reset
// abort behaviour.
module tb_division;

  localparam int unsigned W   = 32;
  localparam int unsigned Q   = 16;
  localparam int unsigned LAT = W + Q + 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         valid;
  logic [W-1:0] result;
  logic         dz;
  logic         ov;

  int checks   = 0;
  int failures = 0;

  division #(
    .WIDTH (W),
    .Q_BITS(Q)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .valid      (valid),
    .result     (result),
    .div_by_zero(dz),
    .overflow   (ov)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: exact integer quotient of the scaled dividend, then saturate.
  function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W-1:0] r, output logic z, output logic o);
    logic [63:0] q;
    if (y == 0) begin
      r = '1; z = 1'b1; o = 1'b0;
    end else begin
      q = ({32'd0, x} << Q) / {32'd0, y};
      z = 1'b0;
      if (q > 64'h0000_0000_FFFF_FFFF) begin
        r = '1; o = 1'b1;
      end else begin
        r = q[W-1:0]; o = 1'b0;
      end
    end
  endfunction

  // Present a start for one edge; returns at the negedge after the start edge.
  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    a = x; b = y; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts edges until valid, scrambling operands while the operation runs.
  task automatic wait_valid(output int edges);
    edges = 0;
    while (!valid && edges < 200) begin
      @(negedge clk);
      if (!valid) begin
        a = $urandom; b = $urandom;
      end
      edges++;
    end
  endtask

  task automatic check_done(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                            input int edges, input int exp_edges);
    logic [W-1:0] er;
    logic         ez, eo;
    model(x, y, er, ez, eo);
    chk({tag, ".latency"}, 64'(edges), 64'(exp_edges));
    chk({tag, ".valid"}, 64'(valid), 64'd1);
    chk({tag, ".busy"}, 64'(busy), 64'd1);
    chk({tag, ".result"}, 64'(result), 64'(er));
    chk({tag, ".div_by_zero"}, 64'(dz), 64'(ez));
    chk({tag, ".overflow"}, 64'(ov), 64'(eo));
    @(negedge clk);
    chk({tag, ".pulse_end"}, 64'(valid), 64'd0);
    chk({tag, ".idle"}, 64'(busy), 64'd0);
    chk({tag, ".hold"}, 64'(result), 64'(er));
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y);
    int e;
    launch(x, y);
    wait_valid(e);
    check_done(tag, x, y, e, (y == 0) ? 0 : int'(LAT));
  endtask

  initial begin
    int e;
    int pulses;
    logic [W-1:0] ra, rb;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    #12;
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.valid", 64'(valid), 64'd0);
    chk("rst.result", 64'(result), 64'd0);
    chk("rst.dz", 64'(dz), 64'd0);
    chk("rst.ov", 64'(ov), 64'd0);

    // First start on the first edge after reset release.
    @(negedge clk);
    rst_n = 1'b1;
    a = 32'h0001_8000; b = 32'h0000_8000; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_valid(e);
    check_done("basic_1p5_div_1", 32'h0001_8000, 32'h0000_8000, e, int'(LAT));
    chk("basic.exact", 64'(result), 64'h0003_0000);

    run_op("third", 32'h0001_0000, 32'h0003_0000);
    chk("third.exact", 64'(result), 64'h0000_5555);
    run_op("divzero", 32'h0005_0000, 32'h0000_0000);
    chk("divzero.exact", 64'(result), 64'hFFFF_FFFF);
    run_op("saturate", 32'hFFFF_0000, 32'h0000_0001);
    chk("saturate.ov", 64'(ov), 64'd1);
    run_op("max_by_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    for (int i = 0; i < 14; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = $urandom_range(0, 3);
        1:       rb = $urandom & 32'h000F_FFFF;
        default: rb = $urandom;
      endcase
      run_op($sformatf("rand%0d", i), ra, rb);
    end

    // Starts during RUN and in DONE are ignored; the IDLE start afterwards is taken.
    launch(32'h0002_0000, 32'h0000_4000);
    repeat (9) @(negedge clk);
    a = 32'h1234_0000; b = 32'h0000_0003; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid(e);
    check_done("ignore_run", 32'h0002_0000, 32'h0000_4000, e + 10, int'(LAT));
    // check_done advanced one cycle; replay the DONE-cycle case with a fresh op.
    launch(32'h0000_C000, 32'h0000_4000);
    wait_valid(e);
    pulses = valid ? 1 : 0;
    a = 32'h0003_0000; b = 32'h0001_0000; start = 1'b1;
    @(negedge clk);
    chk("done_start.idle", 64'(busy), 64'd0);
    chk("done_start.result", 64'(result), 64'h0003_0000);
    if (valid) pulses++;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("done_start.one_pulse", 64'(pulses), 64'd1);
    chk("restart.busy", 64'(busy), 64'd1);
    wait_valid(e);
    check_done("restart", 32'h0003_0000, 32'h0001_0000, e, int'(LAT));

    // Reset in the middle of RUN aborts the operation.
    launch(32'h0007_0000, 32'h0002_0000);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort.busy", 64'(busy), 64'd0);
    chk("abort.valid", 64'(valid), 64'd0);
    chk("abort.result", 64'(result), 64'd0);
    chk("abort.dz", 64'(dz), 64'd0);
    chk("abort.ov", 64'(ov), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (valid || busy) pulses++;
    end
    chk("abort.no_activity", 64'(pulses), 64'd0);
    chk("abort.result_kept", 64'(result), 64'd0);
    run_op("after_abort", 32'h0007_0000, 32'h0002_0000);
    chk("after_abort.exact", 64'(result), 64'h0003_8000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
